// File: rtl/regfile_writeback_pkg.sv
// regfile_writeback_pkg: shared widths and the write-back entry type.
// Holds XLEN, register-address width, register count and the {rd, data}
// record that flows through the load FIFO and the write-port selector.
package regfile_writeback_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: bundle of all write-back traffic around the block.
// master side drives ALU/load results, issue info and scoreboard queries;
// slave side (the write-back unit) returns ld_ready, busy bits, the
// registered register-file write port and the sticky ld_overflow flag.
interface regfile_writeback_if;
    import regfile_writeback_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic                  busy_rs1;
    logic                  busy_rs2;
    logic                  wr_regfile;
    logic [XLEN-1:0]       wr_regfile_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  ld_overflow;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               iss_valid, iss_rd, rs1_q, rs2_q,
        input  ld_ready, busy_rs1, busy_rs2, wr_regfile, wr_regfile_data,
               rd, ld_overflow
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
               iss_valid, iss_rd, rs1_q, rs2_q,
        output ld_ready, busy_rs1, busy_rs2, wr_regfile, wr_regfile_data,
               rd, ld_overflow
    );
endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// wb_fifo: synchronous FIFO buffering load results.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_pop (ignored when
// full/empty respectively), i_din, o_full, o_empty, o_head (oldest entry).
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_push;
    logic         w_pop;

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_empty = r_wp == r_rp;
    assign o_head  = r_mem[r_rp[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and load results onto the register-file write port.
// Ports: CLK, RST_X (async active-low), bus (slave modport) carrying ALU and
// load inputs, issue/scoreboard queries, ld_ready, busy_rs1/2, the registered
// write port (wr_regfile, wr_regfile_data, rd) and sticky ld_overflow.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input logic                 CLK,
    input logic                 RST_X,
    regfile_writeback_if.slave  bus
);
    wb_entry_t             w_head;
    wb_entry_t             w_sel;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_sel_valid;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic                  r_wr;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_data;
    logic [NUM_REGS-1:0]   r_sb;
    logic                  r_ovf;

    wb_fifo #(.DEPTH(LD_DEPTH), .W($bits(wb_entry_t))) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_X),
        .i_push  (bus.ld_valid),
        .i_pop   (w_pop),
        .i_din   ({bus.ld_rd, bus.ld_data}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // ALU always wins the port; the FIFO drains only in ALU-idle cycles.
    assign w_pop       = !bus.alu_valid && !w_empty;
    assign w_sel_valid = bus.alu_valid || !w_empty;
    assign w_sel       = bus.alu_valid ? wb_entry_t'{bus.alu_rd, bus.alu_data} : w_head;
    assign w_set       = (bus.iss_valid && bus.iss_rd != '0) ? NUM_REGS'(1) << bus.iss_rd : '0;
    assign w_clr       = w_sel_valid ? NUM_REGS'(1) << w_sel.rd : '0;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_wr   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
            r_sb   <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_wr <= w_sel_valid && w_sel.rd != '0;
            if (w_sel_valid) begin
                r_rd   <= w_sel.rd;
                r_data <= w_sel.data;
            end
            // Set after clear: a newly issued producer is younger than the retiring one.
            r_sb <= (r_sb & ~w_clr) | w_set;
            if (bus.ld_valid && w_full) r_ovf <= 1'b1;
        end
    end

    // The write being presented now commits on the next negedge, so it still counts as busy.
    assign bus.busy_rs1        = r_sb[bus.rs1_q] || (r_wr && r_rd == bus.rs1_q);
    assign bus.busy_rs2        = r_sb[bus.rs2_q] || (r_wr && r_rd == bus.rs2_q);
    assign bus.ld_ready        = !w_full;
    assign bus.wr_regfile      = r_wr;
    assign bus.wr_regfile_data = r_data;
    assign bus.rd              = r_rd;
    assign bus.ld_overflow     = r_ovf;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;
    logic CLK = 1'b0;
    logic RST_X = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    regfile_writeback_if bus();

    regfile_writeback #(.LD_DEPTH(2)) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.iss_valid = 1'b0;
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.rs1_q = '0; bus.rs2_q = '0;
        #3;
        chk("rst_wr", bus.wr_regfile, 0);
        chk("rst_rd", bus.rd, 0);
        chk("rst_data", bus.wr_regfile_data, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_ovf", bus.ld_overflow, 0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1_q = 5'(i); bus.rs2_q = 5'(31 - i);
            #0.1;
            chk("rst_busy1", bus.busy_rs1, 0);
            chk("rst_busy2", bus.busy_rs2, 0);
        end
        @(negedge CLK);
        RST_X = 1'b1;

        // ALU alone
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        cyc();
        chk("alu_wr", bus.wr_regfile, 1);
        chk("alu_rd", bus.rd, 5);
        chk("alu_data", bus.wr_regfile_data, 32'h1234);
        idle();
        cyc();
        chk("alu_wr_off", bus.wr_regfile, 0);
        chk("alu_rd_hold", bus.rd, 5);
        chk("alu_data_hold", bus.wr_regfile_data, 32'h1234);

        // Contention: load waits behind three ALU results
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'hAA;
        cyc();
        chk("ct1_rd", bus.rd, 1);
        chk("ct1_data", bus.wr_regfile_data, 32'h11);
        bus.ld_valid = 1'b0; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
        cyc();
        chk("ct2_rd", bus.rd, 2);
        bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
        cyc();
        chk("ct3_rd", bus.rd, 3);
        chk("ct3_wr", bus.wr_regfile, 1);
        idle();
        cyc();
        chk("ct4_wr", bus.wr_regfile, 1);
        chk("ct4_rd", bus.rd, 7);
        chk("ct4_data", bus.wr_regfile_data, 32'hAA);
        cyc();
        chk("ct5_wr", bus.wr_regfile, 0);
        chk("ct5_ready", bus.ld_ready, 1);

        // FIFO full and overflow
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h10;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd11; bus.ld_data = 32'hB1;
        cyc();
        chk("fl1_ready", bus.ld_ready, 1);
        bus.alu_rd = 5'd13; bus.alu_data = 32'h13;
        bus.ld_rd = 5'd12; bus.ld_data = 32'hB2;
        cyc();
        chk("fl2_ready", bus.ld_ready, 0);
        chk("fl2_ovf", bus.ld_overflow, 0);
        bus.alu_rd = 5'd15; bus.alu_data = 32'h15;
        bus.ld_rd = 5'd14; bus.ld_data = 32'hB3;
        cyc();
        chk("fl3_ovf", bus.ld_overflow, 1);
        chk("fl3_ready", bus.ld_ready, 0);
        chk("fl3_rd", bus.rd, 15);
        idle();
        cyc();
        chk("dr1_wr", bus.wr_regfile, 1);
        chk("dr1_rd", bus.rd, 11);
        chk("dr1_data", bus.wr_regfile_data, 32'hB1);
        cyc();
        chk("dr2_rd", bus.rd, 12);
        chk("dr2_data", bus.wr_regfile_data, 32'hB2);
        chk("dr2_ready", bus.ld_ready, 1);
        cyc();
        chk("dr3_wr", bus.wr_regfile, 0);
        chk("dr3_ovf_sticky", bus.ld_overflow, 1);

        // Scoreboard: issue then load writeback to r9
        bus.rs1_q = 5'd9; bus.rs2_q = 5'd9;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        cyc();
        bus.iss_valid = 1'b0;
        #0.1;
        chk("sb_set1", bus.busy_rs1, 1);
        chk("sb_set2", bus.busy_rs2, 1);
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h99;
        cyc();
        bus.ld_valid = 1'b0;
        chk("sb_pushed_busy", bus.busy_rs1, 1);
        cyc();
        chk("sb_wb_wr", bus.wr_regfile, 1);
        chk("sb_wb_rd", bus.rd, 9);
        chk("sb_wb_busy", bus.busy_rs1, 1);
        cyc();
        chk("sb_after_busy1", bus.busy_rs1, 0);
        chk("sb_after_busy2", bus.busy_rs2, 0);

        // Same-cycle set and clear on r9: set wins
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        cyc();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h5;
        cyc();
        idle();
        chk("sc_busy_out", bus.busy_rs1, 1);
        cyc();
        chk("sc_wr_off", bus.wr_regfile, 0);
        chk("sc_busy_kept", bus.busy_rs1, 1);
        bus.alu_valid = 1'b1;
        cyc();
        idle();
        cyc();
        chk("sc_cleared", bus.busy_rs1, 0);

        // x0 handling
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        bus.rs1_q = 5'd0; bus.rs2_q = 5'd0;
        cyc();
        idle();
        chk("x0_wr", bus.wr_regfile, 0);
        chk("x0_busy1", bus.busy_rs1, 0);
        cyc();
        chk("x0_busy2", bus.busy_rs2, 0);
        chk("x0_wr2", bus.wr_regfile, 0);

        // Reset mid-burst
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd21; bus.ld_data = 32'hC1;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd25;
        cyc();
        bus.ld_rd = 5'd22; bus.ld_data = 32'hC2; bus.iss_valid = 1'b0;
        bus.rs1_q = 5'd25;
        cyc();
        idle();
        chk("mb_full", bus.ld_ready, 0);
        chk("mb_busy", bus.busy_rs1, 1);
        @(negedge CLK);
        RST_X = 1'b0;
        #1;
        chk("mb_rst_wr", bus.wr_regfile, 0);
        chk("mb_rst_ready", bus.ld_ready, 1);
        chk("mb_rst_ovf", bus.ld_overflow, 0);
        chk("mb_rst_busy", bus.busy_rs1, 0);
        chk("mb_rst_rd", bus.rd, 0);
        @(negedge CLK);
        RST_X = 1'b1;
        cyc();
        chk("mb_post_wr1", bus.wr_regfile, 0);
        cyc();
        chk("mb_post_wr2", bus.wr_regfile, 0);
        chk("mb_post_ready", bus.ld_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end for the 32x32 register file. Merges results from the single-cycle ALU path and the multi-cycle load path into the single register-file write port (wr_regfile, wr_regfile_data, rd).
- Buffers load results in a small FIFO so the ALU path is never stalled.
- Keeps a per-register pending-write scoreboard that issue logic queries for RAW hazards.

Parameters:
- LD_DEPTH, 2, load-result FIFO entries; power of two, at least 2.
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_X  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  FIFO can accept a load result.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load result.
- iss_valid  in  1  an instruction with a destination is issuing.
- iss_rd  in  5  destination of the issuing instruction.
- rs1_q  in  5  scoreboard query address 1.
- rs2_q  in  5  scoreboard query address 2.
- busy_rs1  out  1  pending write to rs1_q.
- busy_rs2  out  1  pending write to rs2_q.
- wr_regfile  out  1  register-file write enable (registered).
- wr_regfile_data  out  XLEN  write data (registered).
- rd  out  5  write address (registered).
- ld_overflow  out  1  sticky error flag: a load was offered while full.

Behaviour:
- Reset (RST_X low, async) clears:
  - wr_regfile=0, wr_regfile_data=0, rd=0;
  - FIFO empty, so ld_ready=1;
  - scoreboard all-zero;
  - ld_overflow=0.
- Reset mid-operation drops all buffered loads and pending bits with no write emitted.
- Load FIFO:
  - Push when ld_valid && ld_ready. ld_ready = !full and is combinational from FIFO state only.
  - Pointers are log2(LD_DEPTH)+1 bits wide and wrap modulo 2*LD_DEPTH.
  - Full when the MSBs differ and the low bits are equal.
  - ld_valid while full sets ld_overflow, which is sticky until reset; the data is discarded.
- Write-port arbitration, evaluated each posedge:
  - alu_valid=1: ALU wins. Outputs take wr_regfile=1, rd=alu_rd, wr_regfile_data=alu_data next cycle. The FIFO holds.
  - else FIFO non-empty: pop the head and drive it onto the outputs next cycle.
  - else: wr_regfile=0. rd and data hold their previous values.
  - Latency is one cycle from accepted input to output.
  - Push and pop in the same cycle are allowed, including when full (pop frees a slot only for the next cycle; ld_ready stays low that cycle).
- x0 handling:
  - A result with destination 0 is consumed (popped or accepted) but emitted with wr_regfile=0.
  - iss_rd=0 never sets a busy bit; bit 0 reads 0 permanently.
- Scoreboard, 32 bits:
  - Set: iss_valid && iss_rd!=0 sets bit iss_rd.
  - Clear: a selected write (ALU accept or FIFO pop) with destination d clears bit d.
  - Set and clear on the same register in the same cycle: set wins, because the new producer is younger.
  - busy_rsN = bit[rsN_q], combinational.
  - busy_rsN is also 1 when the queried register equals the current registered rd with wr_regfile=1. The register file commits on the following negedge, so the value is not yet readable.
- Ordering: loads drain in FIFO order. The pipeline never has two outstanding producers for one register, so the ALU/load reordering is architecturally safe.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, NUM_REGS=32, and a wb_entry_t struct {rd[4:0], data[XLEN-1:0]}.
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO.
  - Interface: push/pop/full/empty/head.
  - Reset: async active-low.
- Arbitration, output registers and scoreboard stay in the top module.

Test Plan:
- Reset release: every output 0, ld_ready=1, busy_rs1/rs2=0 for all addresses; hold RST_X low mid-burst -> FIFO empties, no write emitted.
- ALU alone: alu_valid, rd=5, data=0x1234 -> next cycle wr_regfile=1, rd=5, wr_regfile_data=0x1234; the cycle after, wr_regfile=0.
- Contention: load rd=7/0xAA pushed while alu_valid is asserted for 3 cycles (rd 1,2,3) -> writes in order 1,2,3, then 7/0xAA in the 4th output cycle.
- FIFO full: push 2 loads while ALU is busy -> ld_ready=0; a 3rd ld_valid sets ld_overflow=1; ALU idle -> 2 writes drain, then ld_ready=1.
- Scoreboard: iss rd=9 -> busy for rs1_q=9 = 1; load rd=9 written -> busy still 1 during the output cycle, then 0. Same-cycle iss rd=9 and writeback rd=9 -> bit stays 1.
- x0: alu rd=0 data=0xFFFF -> wr_regfile stays 0; iss_rd=0 -> busy for rs1_q=0 stays 0.
